// File: rtl/octave_decimator.sv
// octave_decimator: keeps even-row/even-column pixels of the blurred raster
// stream and presents them through a first-word-fall-through FIFO with a
// valid/ready handshake and start/done framing for the next octave.
module octave_decimator #(
  parameter int WIDTH      = 128,
  parameter int HEIGHT     = 128,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] pixel_in,
  input  logic       pixel_in_valid,
  input  logic       frame_done_in,
  output logic       start_out,
  output logic [7:0] pixel_out,
  output logic       pixel_out_valid,
  input  logic       pixel_out_ready,
  output logic       done,
  output logic       overflow,
  output logic       short_frame
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [7:0]  COL_LAST  = 8'(WIDTH - 1);
  localparam logic [16:0] IN_LAST   = 17'(WIDTH * HEIGHT - 1);
  localparam logic [14:0] OUT_TOTAL = 15'((WIDTH / 2) * (HEIGHT / 2));

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [7:0]  r_col;
  logic [7:0]  r_row;
  logic [16:0] r_in_cnt;
  logic [14:0] r_out_cnt;
  logic [14:0] r_kept_cnt;
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic        r_start_out;
  logic        r_overflow;
  logic        r_short;

  logic        w_empty;
  logic        w_full;
  logic        w_accept;
  logic        w_keep;
  logic        w_push;
  logic        w_pop;
  logic        w_drop;
  logic        w_last_in;
  logic        w_short_evt;
  logic        w_done;

  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop       = !w_empty && pixel_out_ready;
  // start takes priority: a pixel arriving with start is never accepted
  assign w_accept    = (r_state == S_RUN) && pixel_in_valid && !start;
  assign w_keep      = w_accept && !r_row[0] && !r_col[0];
  assign w_push      = w_keep && (!w_full || w_pop);
  assign w_drop      = w_keep && w_full && !w_pop;
  assign w_last_in   = w_accept && (r_in_cnt == IN_LAST);
  assign w_short_evt = (r_state == S_RUN) && !start && frame_done_in && !w_last_in;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; start restarts from any state
  always_comb begin
    w_next = r_state;
    if (start) begin
      w_next = S_RUN;
    end else begin
      unique case (r_state)
        S_IDLE:  w_next = S_IDLE;
        S_RUN: begin
          if (w_done)                        w_next = S_IDLE;
          else if (w_last_in || w_short_evt) w_next = S_DRAIN;
        end
        S_DRAIN: if (w_done) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Done detection. In RUN the out counter can only reach the full-frame
  // target once every kept pixel has been transferred or dropped, so done may
  // fire before the trailing non-kept input pixels; in DRAIN the target is
  // the number of pixels actually kept (covers short frames).
  always_comb begin
    w_done = 1'b0;
    unique case (r_state)
      S_RUN:   w_done = !start && (r_out_cnt == OUT_TOTAL);
      S_DRAIN: w_done = !start && (r_out_cnt == r_kept_cnt);
      default: w_done = 1'b0;
    endcase
  end

  // Raster position, frame counters and sticky status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col      <= '0;
      r_row      <= '0;
      r_in_cnt   <= '0;
      r_out_cnt  <= '0;
      r_kept_cnt <= '0;
      r_overflow <= 1'b0;
      r_short    <= 1'b0;
    end else if (start) begin
      r_col      <= '0;
      r_row      <= '0;
      r_in_cnt   <= '0;
      r_out_cnt  <= '0;
      r_kept_cnt <= '0;
      r_overflow <= 1'b0;
      r_short    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_in_cnt <= r_in_cnt + 17'd1;
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= r_row + 8'd1;
        end else begin
          r_col <= r_col + 8'd1;
        end
      end
      if (w_keep)          r_kept_cnt <= r_kept_cnt + 15'd1;
      if (w_pop || w_drop) r_out_cnt  <= r_out_cnt + 15'd1;
      if (w_drop)          r_overflow <= 1'b1;
      if (w_short_evt)     r_short    <= 1'b1;
    end
  end

  // FIFO pointers; start flushes any leftover contents
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (start) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= pixel_in;
  end

  // start_out follows start by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_start_out <= 1'b0;
    else     r_start_out <= start;
  end

  // Output drive; head entry is gated so pixel_out reads 0 when empty
  always_comb begin
    pixel_out_valid = !w_empty;
    pixel_out       = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    start_out       = r_start_out;
    done            = w_done;
    overflow        = r_overflow;
    short_frame     = r_short;
  end

endmodule

// File: tb/tb_octave_decimator.sv
// Directed bench for octave_decimator on an 8x8 frame, with a 16-entry and a
// 4-entry FIFO instance sharing the same input stimulus.
module tb_octave_decimator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] pixel_in;
  logic       pixel_in_valid;
  logic       frame_done_in;
  logic       pixel_out_ready;

  logic       start_out,   start_out_4;
  logic [7:0] pixel_out,   pixel_out_4;
  logic       pixel_out_valid, pixel_out_valid_4;
  logic       done,        done_4;
  logic       overflow,    overflow_4;
  logic       short_frame, short_frame_4;

  int n_cmp = 0;
  int n_err = 0;

  int         cyc = 0;
  logic [7:0] cap[$];
  logic [7:0] cap4[$];
  int         done_cnt, done4_cnt, done_cyc, xfer_cyc, stall_err;
  logic       stall_hold;
  logic [7:0] stall_pix;

  octave_decimator #(.WIDTH(8), .HEIGHT(8), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .pixel_in(pixel_in),
    .pixel_in_valid(pixel_in_valid), .frame_done_in(frame_done_in),
    .start_out(start_out), .pixel_out(pixel_out), .pixel_out_valid(pixel_out_valid),
    .pixel_out_ready(pixel_out_ready), .done(done), .overflow(overflow),
    .short_frame(short_frame)
  );

  octave_decimator #(.WIDTH(8), .HEIGHT(8), .FIFO_DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .pixel_in(pixel_in),
    .pixel_in_valid(pixel_in_valid), .frame_done_in(frame_done_in),
    .start_out(start_out_4), .pixel_out(pixel_out_4), .pixel_out_valid(pixel_out_valid_4),
    .pixel_out_ready(pixel_out_ready), .done(done_4), .overflow(overflow_4),
    .short_frame(short_frame_4)
  );

  always #5 clk = ~clk;

  // Output monitor: samples 1 ns after each falling edge (inputs already set
  // for the coming rising edge), so a recorded transfer happens at that edge.
  always begin
    @(negedge clk);
    #1;
    cyc++;
    if (pixel_out_valid && pixel_out_ready) begin
      cap.push_back(pixel_out);
      xfer_cyc = cyc;
    end
    if (pixel_out_valid_4 && pixel_out_ready) cap4.push_back(pixel_out_4);
    if (done) begin
      done_cnt++;
      if (done_cnt == 1) done_cyc = cyc;
    end
    if (done_4) done4_cnt++;
    if (stall_hold && (!pixel_out_valid || pixel_out !== stall_pix)) stall_err++;
    stall_hold = pixel_out_valid && !pixel_out_ready;
    stall_pix  = pixel_out;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_mon();
    cap.delete();
    cap4.delete();
    done_cnt   = 0;
    done4_cnt  = 0;
    done_cyc   = -1;
    xfer_cyc   = -1;
    stall_err  = 0;
    stall_hold = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // rmode: 0 ready high, 1 ready low, 2 ready alternating (opposite of valid toggle)
  task automatic feed(input int npix, input bit vtoggle, input int rmode);
    int p = 0;
    int k = 0;
    while (p < npix) begin
      pixel_in_valid  = vtoggle ? k[0] : 1'b1;
      pixel_in        = 8'(p);
      pixel_out_ready = (rmode == 1) ? 1'b0 : (rmode == 2) ? ~k[0] : 1'b1;
      if (pixel_in_valid) p++;
      @(negedge clk);
      k++;
    end
    pixel_in_valid = 1'b0;
  endtask

  task automatic wait_done(input int rmode, output bit ok);
    int k = 0;
    while ((done_cnt == 0 || done4_cnt == 0) && k < 400) begin
      pixel_out_ready = (rmode == 2) ? k[0] : 1'b1;
      @(negedge clk);
      k++;
    end
    ok = (done_cnt != 0) && (done4_cnt != 0);
    pixel_out_ready = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({start_out, pixel_out, pixel_out_valid, done, overflow, short_frame} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b, expected all zero",
               {start_out, pixel_out, pixel_out_valid, done, overflow, short_frame});
    end
    n_cmp++;
    if ({start_out_4, pixel_out_4, pixel_out_valid_4, done_4, overflow_4, short_frame_4} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_outputs_4: got %b, expected all zero",
               {start_out_4, pixel_out_4, pixel_out_valid_4, done_4, overflow_4, short_frame_4});
    end
  endtask

  task automatic test_basic();
    bit ok;
    clear_mon();
    pixel_out_ready = 1'b1;
    do_start();
    n_cmp++;
    if (start_out !== 1'b1) begin
      n_err++;
      $display("FAIL basic_start_out: got %b, expected 1", start_out);
    end
    feed(64, 1'b0, 0);
    wait_done(0, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL basic_done_timeout: got no done, expected done"); end
    n_cmp++;
    if (cap.size() != 16) begin
      n_err++;
      $display("FAIL basic_count: got %0d outputs, expected 16", cap.size());
    end
    for (int i = 0; i < cap.size() && i < 16; i++) begin
      n_cmp++;
      if (cap[i] !== 8'((i / 4) * 16 + (i % 4) * 2)) begin
        n_err++;
        $display("FAIL basic_pix[%0d]: got %0d, expected %0d", i, cap[i], (i / 4) * 16 + (i % 4) * 2);
      end
    end
    n_cmp++;
    if (done_cnt != 1) begin n_err++; $display("FAIL basic_done_cnt: got %0d, expected 1", done_cnt); end
    n_cmp++;
    if (done_cyc != xfer_cyc + 1) begin
      n_err++;
      $display("FAIL basic_done_timing: got cycle %0d, expected %0d", done_cyc, xfer_cyc + 1);
    end
    n_cmp++;
    if ({overflow, short_frame} !== 2'b00) begin
      n_err++;
      $display("FAIL basic_flags: got %b, expected 00", {overflow, short_frame});
    end
    n_cmp++;
    if (cap4.size() != 16) begin
      n_err++;
      $display("FAIL basic_count_4: got %0d outputs, expected 16", cap4.size());
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_mon();
    do_start();
    feed(64, 1'b0, 1);
    n_cmp++;
    if ({pixel_out_valid, pixel_out, overflow} !== {1'b1, 8'd0, 1'b0}) begin
      n_err++;
      $display("FAIL bp_held: got valid=%b pix=%0d ovf=%b, expected valid=1 pix=0 ovf=0",
               pixel_out_valid, pixel_out, overflow);
    end
    n_cmp++;
    if (overflow_4 !== 1'b1) begin n_err++; $display("FAIL bp_overflow_4: got %b, expected 1", overflow_4); end
    n_cmp++;
    if (done_cnt != 0) begin n_err++; $display("FAIL bp_early_done: got %0d, expected 0", done_cnt); end
    wait_done(0, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL bp_done_timeout: got no done, expected done"); end
    n_cmp++;
    if (cap.size() != 16) begin n_err++; $display("FAIL bp_count: got %0d, expected 16", cap.size()); end
    for (int i = 0; i < cap.size() && i < 16; i++) begin
      n_cmp++;
      if (cap[i] !== 8'((i / 4) * 16 + (i % 4) * 2)) begin
        n_err++;
        $display("FAIL bp_pix[%0d]: got %0d, expected %0d", i, cap[i], (i / 4) * 16 + (i % 4) * 2);
      end
    end
    n_cmp++;
    if (cap4.size() != 4) begin n_err++; $display("FAIL bp_count_4: got %0d, expected 4", cap4.size()); end
    for (int i = 0; i < cap4.size() && i < 4; i++) begin
      n_cmp++;
      if (cap4[i] !== 8'(i * 2)) begin
        n_err++;
        $display("FAIL bp_pix_4[%0d]: got %0d, expected %0d", i, cap4[i], i * 2);
      end
    end
    n_cmp++;
    if (done_cyc != xfer_cyc + 1) begin
      n_err++;
      $display("FAIL bp_done_timing: got cycle %0d, expected %0d", done_cyc, xfer_cyc + 1);
    end
    n_cmp++;
    if (overflow_4 !== 1'b1) begin n_err++; $display("FAIL bp_overflow_sticky_4: got %b, expected 1", overflow_4); end
  endtask

  task automatic test_toggle();
    bit ok;
    clear_mon();
    do_start();
    n_cmp++;
    if (overflow_4 !== 1'b0) begin n_err++; $display("FAIL tg_overflow_cleared_4: got %b, expected 0", overflow_4); end
    feed(64, 1'b1, 2);
    wait_done(2, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL tg_done_timeout: got no done, expected done"); end
    n_cmp++;
    if (cap.size() != 16) begin n_err++; $display("FAIL tg_count: got %0d, expected 16", cap.size()); end
    for (int i = 0; i < cap.size() && i < 16; i++) begin
      n_cmp++;
      if (cap[i] !== 8'((i / 4) * 16 + (i % 4) * 2)) begin
        n_err++;
        $display("FAIL tg_pix[%0d]: got %0d, expected %0d", i, cap[i], (i / 4) * 16 + (i % 4) * 2);
      end
    end
    n_cmp++;
    if (cap4.size() != 16) begin n_err++; $display("FAIL tg_count_4: got %0d, expected 16", cap4.size()); end
    n_cmp++;
    if (stall_err != 0) begin n_err++; $display("FAIL tg_stall_stable: got %0d violations, expected 0", stall_err); end
    n_cmp++;
    if ({overflow, overflow_4, done_cnt == 1} !== 3'b001) begin
      n_err++;
      $display("FAIL tg_flags: got ovf=%b ovf4=%b done_cnt=%0d, expected 0 0 1", overflow, overflow_4, done_cnt);
    end
  endtask

  task automatic test_short();
    bit ok;
    clear_mon();
    do_start();
    feed(20, 1'b0, 0);
    frame_done_in = 1'b1;
    @(negedge clk);
    frame_done_in = 1'b0;
    wait_done(0, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL sf_done_timeout: got no done, expected done"); end
    n_cmp++;
    if ({short_frame, short_frame_4} !== 2'b11) begin
      n_err++;
      $display("FAIL sf_flag: got %b, expected 11", {short_frame, short_frame_4});
    end
    n_cmp++;
    if (cap.size() != 6) begin n_err++; $display("FAIL sf_count: got %0d, expected 6", cap.size()); end
    for (int i = 0; i < cap.size() && i < 6; i++) begin
      n_cmp++;
      if (cap[i] !== 8'((i / 4) * 16 + (i % 4) * 2)) begin
        n_err++;
        $display("FAIL sf_pix[%0d]: got %0d, expected %0d", i, cap[i], (i / 4) * 16 + (i % 4) * 2);
      end
    end
    n_cmp++;
    if (done_cnt != 1) begin n_err++; $display("FAIL sf_done_cnt: got %0d, expected 1", done_cnt); end
    n_cmp++;
    if (overflow !== 1'b0) begin n_err++; $display("FAIL sf_overflow: got %b, expected 0", overflow); end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    clear_mon();
    do_start();
    feed(30, 1'b0, 1);
    n_cmp++;
    if ({pixel_out_valid, overflow_4} !== 2'b11) begin
      n_err++;
      $display("FAIL rm_pre_state: got valid=%b ovf4=%b, expected 1 1", pixel_out_valid, overflow_4);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({start_out, pixel_out, pixel_out_valid, done, overflow, short_frame} !== 13'd0) begin
      n_err++;
      $display("FAIL rm_async_clear: got %b, expected all zero",
               {start_out, pixel_out, pixel_out_valid, done, overflow, short_frame});
    end
    n_cmp++;
    if ({pixel_out_valid_4, overflow_4} !== 2'b00) begin
      n_err++;
      $display("FAIL rm_async_clear_4: got %b, expected 00", {pixel_out_valid_4, overflow_4});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_mon();
    pixel_out_ready = 1'b1;
    do_start();
    n_cmp++;
    if (start_out !== 1'b1) begin n_err++; $display("FAIL rm_start_out: got %b, expected 1", start_out); end
    feed(64, 1'b0, 0);
    wait_done(0, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL rm_done_timeout: got no done, expected done"); end
    n_cmp++;
    if (cap.size() != 16) begin n_err++; $display("FAIL rm_count: got %0d, expected 16", cap.size()); end
    for (int i = 0; i < cap.size() && i < 16; i++) begin
      n_cmp++;
      if (cap[i] !== 8'((i / 4) * 16 + (i % 4) * 2)) begin
        n_err++;
        $display("FAIL rm_pix[%0d]: got %0d, expected %0d", i, cap[i], (i / 4) * 16 + (i % 4) * 2);
      end
    end
    n_cmp++;
    if (done_cyc != xfer_cyc + 1) begin
      n_err++;
      $display("FAIL rm_done_timing: got cycle %0d, expected %0d", done_cyc, xfer_cyc + 1);
    end
  endtask

  initial begin
    rst             = 1'b1;
    start           = 1'b0;
    pixel_in        = '0;
    pixel_in_valid  = 1'b0;
    frame_done_in   = 1'b0;
    pixel_out_ready = 1'b0;
    clear_mon();
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_basic();
    test_backpressure();
    test_toggle();
    test_short();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/octave_decimator.md
Name: octave_decimator

Overview:
- Downstream stage of the vertical Gaussian blur. Consumes the blurred raster stream (8-bit pixel, valid strobe, end-of-frame done pulse).
- Keeps even-row/even-column samples, producing the half-resolution base image for the next SIFT octave.
- Buffers kept pixels in a small FIFO and presents them on a valid/ready interface with start/done framing, so it can feed the next octave's blur chain.

Parameters:
- WIDTH, 128, input frame width in pixels (even, 4..256)
- HEIGHT, 128, input frame height in pixels (even, 4..256)
- FIFO_DEPTH, 16, output FIFO entries (power of two, >=2)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse: arm for a new input frame
- pixel_in  in  8  blurred pixel, raster order
- pixel_in_valid  in  1  pixel_in qualifier
- frame_done_in  in  1  upstream end-of-frame pulse
- start_out  out  1  one-cycle pulse to the downstream stage
- pixel_out  out  8  decimated pixel
- pixel_out_valid  out  1  pixel_out holds data (FIFO non-empty)
- pixel_out_ready  in  1  downstream accepts pixel_out this cycle
- done  out  1  one-cycle pulse after the last output pixel transfers
- overflow  out  1  sticky: a kept pixel was dropped because the FIFO was full
- short_frame  out  1  sticky: frame_done_in arrived before WIDTH*HEIGHT input pixels

Behaviour:
- Reset: all outputs 0. State IDLE. Counters and FIFO pointers cleared. Takes effect immediately and asynchronously, including mid-frame; any FIFO contents are discarded.
- States:
  - IDLE: pixel_in_valid ignored.
  - On start: clear col/row/out counters, FIFO, overflow and short_frame. Pulse start_out the next cycle. Go to RUN.
  - RUN: each pixel_in_valid advances col. At col==WIDTH-1, col wraps to 0 and row increments. The pixel is kept iff row[0]==0 and col[0]==0. After input pixel WIDTH*HEIGHT-1 is accepted, go to DRAIN; later input pixels are ignored.
  - DRAIN: input ignored. When the out counter reaches (WIDTH/2)*(HEIGHT/2) transfers, pulse done for one cycle and go to IDLE.
- Push and pop:
  - Kept pixel with FIFO not full: push.
  - Kept pixel with FIFO full and no pop in the same cycle: drop it, set overflow.
  - Simultaneous push and pop on a full FIFO: both succeed, occupancy unchanged.
- Output side:
  - FIFO is first-word-fall-through.
  - pixel_out_valid = !empty; pixel_out = head entry.
  - Transfer when pixel_out_valid && pixel_out_ready. The out counter increments per transfer.
  - pixel_out must stay stable while valid && !ready.
- Counting of dropped pixels:
  - Dropped pixels count toward the out counter so that done still fires.
  - Out counter target = (WIDTH/2)*(HEIGHT/2) transfers plus drops.
- Latency: kept pixel accepted in cycle N → pixel_out_valid in cycle N+1 when the FIFO was empty.
- frame_done_in:
  - In RUN with fewer than WIDTH*HEIGHT pixels accepted: set short_frame, go to DRAIN, and complete done once the FIFO empties. The done count then uses pixels actually kept.
  - In DRAIN or IDLE: ignored.
- start while RUN/DRAIN: restart as from IDLE; FIFO flushed; no done for the aborted frame.
- Same-cycle start and pixel_in_valid in IDLE: the pixel is ignored.
- Widths:
  - col/row: 8 bits.
  - Input count: 17 bits.
  - Out count: 15 bits.
  - FIFO pointers: log2(FIFO_DEPTH)+1 bits.

Test Plan:
- WIDTH=HEIGHT=8, start, 64 pixels with value row*8+col, ready=1 → start_out one cycle after start. 16 outputs 0,2,4,6,16,18,20,22,32,...,54. done one cycle after the transfer of 54. overflow=short_frame=0.
- Same frame, ready=0 throughout input, FIFO_DEPTH=16 → 16 entries held, overflow=0. Raise ready: 16 transfers in order, then done.
- FIFO_DEPTH=4, ready=0 during input → first 4 kept pixels (0,2,4,6) retained, overflow=1. After ready rises, exactly 4 outputs, then done.
- Pixel_in_valid toggling every other cycle, ready toggling → output sequence identical to the first scenario. pixel_out stable whenever valid && !ready.
- frame_done_in after 20 of 64 pixels (kept: 0,2,4,6,16,18) → short_frame=1, 6 outputs, done.
- rst asserted mid-frame after 30 pixels → all outputs 0 immediately. A new start plus a full frame reproduces the first scenario's output exactly.
